// File: rtl/gate_cmd_decoder.sv
// Gate command decoder for a 3-phase bridge.
// Validates bytes from a UART receiver and holds the latest good one as a
// pending gate pattern. A rising edge on the asynchronous shoot strobe applies
// that pattern with break-before-make sequencing: gates that turn off do so at
// once, and gates that turn on wait DEAD_CYCLES clocks.
//
// Ports:
//   clk           system clock (48 MHz)
//   reset         asynchronous, active-high reset
//   data_received received byte {d[4:0], c[2:0]}
//   rx_done       one-cycle strobe, data_received/parity_error valid with it
//   parity_error  UART parity flag
//   shoot         asynchronous apply strobe, rising edge acts
//   gates         {g3_b,g3_a,g2_b,g2_a,g1_b,g1_a}, 1 = transistor on
//   cmd_valid     a validated command is pending
//   cmd_error     one-cycle pulse per rejected byte
//   err_count     saturating count of rejected bytes
//   busy          dead-time transition in progress
module gate_cmd_decoder #(
    parameter int unsigned DEAD_CYCLES = 48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_received,
    input  logic       rx_done,
    input  logic       parity_error,
    input  logic       shoot,
    output logic [5:0] gates,
    output logic       cmd_valid,
    output logic       cmd_error,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int unsigned CNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        DEADTIME = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       pend_q, pend_d;
    logic [5:0]       target_q, target_d;
    logic [5:0]       gates_d;
    logic             cmd_valid_d, cmd_error_d, busy_d;
    logic [7:0]       err_count_d;

    // Shoot synchronizer and rising-edge detector
    logic       sync1_q, sync2_q, prev_q;
    logic [1:0] fill_q;
    logic       shoot_edge;

    // One-hot phase select: 0 = none, 1..3 = phase 1..3
    function automatic logic [2:0] phase_sel(input logic [1:0] p);
        logic [2:0] r;
        r = 3'b000;
        case (p)
            2'd1:    r = 3'b001;
            2'd2:    r = 3'b010;
            2'd3:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Byte decode and validation
    logic [4:0] d;
    logic [2:0] c, c_exp, hs, ls;
    logic       en, shoot_thru, byte_ok;
    logic [5:0] pattern;

    always_comb begin
        d          = data_received[7:3];
        c          = data_received[2:0];
        c_exp      = {d[1] ^ d[2] ^ d[4], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
        en         = d[0];
        shoot_thru = en && (d[4:3] == d[2:1]) && (d[4:3] != 2'd0);
        byte_ok    = !parity_error && (c == c_exp) && !shoot_thru;
        hs         = en ? phase_sel(d[4:3]) : 3'b000;
        ls         = en ? phase_sel(d[2:1]) : 3'b000;
        pattern    = {ls[2], hs[2], ls[1], hs[1], ls[0], hs[0]};
    end

    // prev_q is held at 1 until the chain holds post-reset samples, so a
    // shoot already high at reset release never looks like a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b1;
            fill_q  <= 2'b00;
        end else begin
            sync1_q <= shoot;
            sync2_q <= sync1_q;
            prev_q  <= fill_q[1] ? sync2_q : 1'b1;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end

    assign shoot_edge = sync2_q & ~prev_q;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        target_d    = target_q;
        gates_d     = gates;
        cmd_valid_d = cmd_valid;
        cmd_error_d = 1'b0;
        err_count_d = err_count;

        case (state_q)
            IDLE: begin
                if (shoot_edge && cmd_valid) begin
                    // Break first: keep only gates that stay on
                    gates_d     = gates & pend_q;
                    target_d    = pend_q;
                    cmd_valid_d = 1'b0;
                    cnt_d       = CNT_LOAD;
                    state_d     = DEADTIME;
                end
            end
            DEADTIME: begin
                if (cnt_q == '0) begin
                    gates_d = target_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte accepted in the same cycle as a shoot stays pending
        if (rx_done) begin
            if (byte_ok) begin
                pend_d      = pattern;
                cmd_valid_d = 1'b1;
            end else begin
                cmd_error_d = 1'b1;
                if (err_count != 8'hFF) begin
                    err_count_d = err_count + 8'd1;
                end
            end
        end

        busy_d = (state_d == DEADTIME);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            target_q  <= '0;
            gates     <= '0;
            cmd_valid <= 1'b0;
            cmd_error <= 1'b0;
            err_count <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            target_q  <= target_d;
            gates     <= gates_d;
            cmd_valid <= cmd_valid_d;
            cmd_error <= cmd_error_d;
            err_count <= err_count_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_gate_cmd_decoder.sv
// Directed testbench for gate_cmd_decoder with hand-computed expectations.
//   0x6E -> high 1, low 2, en      -> gates 0x09
//   0x9A -> high 2, low 1, en      -> gates 0x06
//   0xBC -> high 2, low 3, en      -> gates 0x24
//   0x6F -> check-bit error; 0x5D -> phase 1 both sides (shoot-through)
module tb_gate_cmd_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_received;
    logic       rx_done;
    logic       parity_error;
    logic       shoot;
    logic [5:0] gates;
    logic       cmd_valid;
    logic       cmd_error;
    logic [7:0] err_count;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    gate_cmd_decoder #(.DEAD_CYCLES(48)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_received (data_received),
        .rx_done       (rx_done),
        .parity_error  (parity_error),
        .shoot         (shoot),
        .gates         (gates),
        .cmd_valid     (cmd_valid),
        .cmd_error     (cmd_error),
        .err_count     (err_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // No phase may ever have both transistors on
    always @(negedge clk) begin
        if (!reset) begin
            check("no_overlap",
                  32'({gates[5] & gates[4], gates[3] & gates[2], gates[1] & gates[0]}), 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic pe);
        @(negedge clk);
        data_received = b;
        parity_error  = pe;
        rx_done       = 1'b1;
        @(posedge clk);
        #1;
        rx_done      = 1'b0;
        parity_error = 1'b0;
    endtask

    // Shoot while nothing valid is pending: nothing may move
    task automatic shoot_ignored(input logic [5:0] exp_gates);
        @(negedge clk);
        shoot = 1'b1;
        repeat (3) @(negedge clk);
        shoot = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("ignored_gates", 32'(gates), 32'(exp_gates));
        check("ignored_busy", 32'(busy), 32'd0);
    endtask

    // mode 0: plain transition
    // mode 1: extra shoot pulse and new accepted byte during dead time
    // mode 2: reset asserted at dead-time cycle 20
    task automatic do_shoot(input logic [5:0] exp_mid, input logic [5:0] exp_fin, input int mode);
        logic [5:0] g0;
        int n;
        g0 = gates;
        @(negedge clk);
        shoot = 1'b1;
        @(posedge clk);
        #1;
        check("edge1_gates", 32'(gates), 32'(g0));
        @(posedge clk);
        #1;
        check("edge2_gates", 32'(gates), 32'(g0));
        check("edge2_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("edge3_gates", 32'(gates), 32'(exp_mid));
        check("edge3_busy", 32'(busy), 32'd1);
        check("edge3_cmd_valid", 32'(cmd_valid), 32'd0);
        n = 0;
        while (busy && n < 200) begin
            if (n == 3) shoot = 1'b0;
            if (mode == 1) begin
                if (n == 10) shoot = 1'b1;
                if (n == 14) shoot = 1'b0;
                if (n == 20) begin
                    data_received = 8'h6E;
                    parity_error  = 1'b0;
                    rx_done       = 1'b1;
                end
                if (n == 21) begin
                    rx_done = 1'b0;
                    check("dt_byte_valid", 32'(cmd_valid), 32'd1);
                    check("dt_byte_gates", 32'(gates), 32'(exp_mid));
                end
            end
            if (mode == 2 && n == 20) begin
                #2;
                reset = 1'b1;
                #1;
                check("rst_async_gates", 32'(gates), 32'd0);
                check("rst_async_busy", 32'(busy), 32'd0);
                check("rst_async_valid", 32'(cmd_valid), 32'd0);
                return;
            end
            @(posedge clk);
            #1;
            n++;
            if (n == 47) check("dt_last_gates", 32'(gates), 32'(exp_mid));
        end
        check("busy_cycles", 32'(n), 32'd48);
        check("final_gates", 32'(gates), 32'(exp_fin));
        check("final_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        data_received = 8'h00;
        rx_done       = 1'b0;
        parity_error  = 1'b0;
        shoot         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gates", 32'(gates), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_error", 32'(cmd_error), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // Check-bit error
        send_byte(8'h6F, 1'b0);
        check("chk_err_pulse", 32'(cmd_error), 32'd1);
        check("chk_err_count", 32'(err_count), 32'd1);
        check("chk_err_valid", 32'(cmd_valid), 32'd0);
        @(posedge clk);
        #1;
        check("chk_err_pulse_end", 32'(cmd_error), 32'd0);
        shoot_ignored(6'h00);

        // Shoot-through and parity error
        send_byte(8'h5D, 1'b0);
        check("st_err_pulse", 32'(cmd_error), 32'd1);
        check("st_err_count", 32'(err_count), 32'd2);
        check("st_err_valid", 32'(cmd_valid), 32'd0);
        send_byte(8'h6E, 1'b1);
        check("par_err_pulse", 32'(cmd_error), 32'd1);
        check("par_err_count", 32'(err_count), 32'd3);
        check("par_err_valid", 32'(cmd_valid), 32'd0);

        // Accepted byte, then apply
        send_byte(8'h6E, 1'b0);
        check("acc_valid", 32'(cmd_valid), 32'd1);
        check("acc_no_error", 32'(cmd_error), 32'd0);
        check("acc_gates_hold", 32'(gates), 32'd0);
        do_shoot(6'h00, 6'h09, 0);

        // 0x09 -> 0x06: g1_a, g2_b off first; g2_a, g1_b on after dead time
        send_byte(8'h9A, 1'b0);
        check("acc2_valid", 32'(cmd_valid), 32'd1);
        do_shoot(6'h00, 6'h06, 0);

        // 0x06 -> 0x24: g2_a holds; extra shoot and new byte in dead time
        send_byte(8'hBC, 1'b0);
        do_shoot(6'h04, 6'h24, 1);
        check("post_dt_valid", 32'(cmd_valid), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("no_retrigger_gates", 32'(gates), 32'h24);
        check("no_retrigger_busy", 32'(busy), 32'd0);

        // Reset in the middle of 0x24 -> 0x09
        do_shoot(6'h00, 6'h09, 2);
        shoot = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("in_rst_gates", 32'(gates), 32'd0);
        @(negedge clk);
        reset         = 1'b0;
        data_received = 8'h6E;
        parity_error  = 1'b0;
        rx_done       = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        check("post_rst_valid", 32'(cmd_valid), 32'd1);
        repeat (60) @(posedge clk);
        #1;
        check("post_rst_gates", 32'(gates), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_still_valid", 32'(cmd_valid), 32'd1);
        shoot = 1'b0;
        repeat (4) @(posedge clk);
        do_shoot(6'h00, 6'h09, 0);

        // Error counter saturation
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h6F, 1'b0);
            if (i == 253) check("err_count_254", 32'(err_count), 32'd254);
            if (i == 254) check("err_count_255", 32'(err_count), 32'd255);
        end
        check("err_count_sat", 32'(err_count), 32'd255);
        check("sat_gates", 32'(gates), 32'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
